// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: saves pc/cause into mepc/mcause, redirects to the
// mtvec handler (direct or vectored), and returns to mepc on mret.
module trap_controller #(
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instrValid,
    input  logic [31:0] pc,
    input  logic        excFetchMisaligned,
    input  logic        excIllegal,
    input  logic        excEbreak,
    input  logic        excEcall,
    input  logic        instrIsMret,
    input  logic        irqExt,
    input  logic        irqTimer,
    input  logic [31:0] mtvecDi,
    input  logic [31:0] mepcDi,
    output logic        mepcWe,
    output logic [31:0] mepcDo,
    output logic        mcauseWe,
    output logic [31:0] mcauseDo,
    output logic        squash,
    output logic        stall,
    output logic        pcWe,
    output logic [31:0] pcTarget,
    output logic        inTrap
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTER,
        S_REDIRECT,
        S_MRET
    } state_t;

    state_t      r_state;
    logic        r_inTrap;
    logic [31:0] r_savedPc;
    logic [31:0] r_savedCause;

    logic        w_irqExtEn;
    logic        w_irqTimerEn;
    logic        w_anyExc;
    logic        w_trap;
    logic        w_mret;
    logic [31:0] w_cause;
    logic [31:0] w_base;
    logic        w_vectored;

    // Interrupts are masked while a handler runs; exceptions are never masked.
    assign w_irqExtEn   = irqExt & ~r_inTrap;
    assign w_irqTimerEn = irqTimer & ~r_inTrap;
    assign w_anyExc     = excFetchMisaligned | excIllegal | excEbreak | excEcall;
    assign w_trap       = instrValid & (w_anyExc | w_irqExtEn | w_irqTimerEn);
    assign w_mret       = instrValid & instrIsMret & ~w_trap;

    always_comb begin
        w_cause = 32'h0000_0000;
        if (w_irqExtEn)              w_cause = 32'h8000_000B;
        else if (w_irqTimerEn)       w_cause = 32'h8000_0007;
        else if (excFetchMisaligned) w_cause = 32'h0000_0000;
        else if (excIllegal)         w_cause = 32'h0000_0002;
        else if (excEbreak)          w_cause = 32'h0000_0003;
        else if (excEcall)           w_cause = 32'h0000_000B;
    end

    assign w_base     = {mtvecDi[31:2], 2'b00};
    assign w_vectored = VECTORED_EN && (mtvecDi[1:0] == 2'b01) && r_savedCause[31];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_inTrap     <= 1'b0;
            r_savedPc    <= 32'h0000_0000;
            r_savedCause <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trap) begin
                        r_savedPc    <= pc;
                        r_savedCause <= w_cause;
                        r_state      <= S_ENTER;
                    end else if (w_mret) begin
                        r_state <= S_MRET;
                    end
                end
                S_ENTER:    r_state <= S_REDIRECT;
                S_REDIRECT: begin
                    r_inTrap <= 1'b1;
                    r_state  <= S_IDLE;
                end
                S_MRET: begin
                    r_inTrap <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode the state; squash/stall in IDLE are held low while reset is asserted.
    always_comb begin
        mepcWe   = 1'b0;
        mepcDo   = 32'h0000_0000;
        mcauseWe = 1'b0;
        mcauseDo = 32'h0000_0000;
        squash   = 1'b0;
        stall    = 1'b0;
        pcWe     = 1'b0;
        pcTarget = 32'h0000_0000;
        case (r_state)
            S_IDLE: begin
                squash = w_trap & reset;
                stall  = w_trap & reset;
            end
            S_ENTER: begin
                mepcWe   = 1'b1;
                mepcDo   = r_savedPc;
                mcauseWe = 1'b1;
                mcauseDo = r_savedCause;
                stall    = 1'b1;
            end
            S_REDIRECT: begin
                pcWe     = 1'b1;
                pcTarget = w_vectored ? (w_base + {r_savedCause[29:0], 2'b00}) : w_base;
                stall    = 1'b1;
            end
            S_MRET: begin
                pcWe     = 1'b1;
                pcTarget = mepcDi;
                stall    = 1'b1;
            end
            default: ;
        endcase
    end

    assign inTrap = r_inTrap;

endmodule

// File: tb/tb_trap_controller.sv
// Testbench for trap_controller: directed scenarios plus randomized commits
// compared against a cause/target/inTrap model of the trap rules.
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        instrValid;
    logic [31:0] pc;
    logic        excFetchMisaligned;
    logic        excIllegal;
    logic        excEbreak;
    logic        excEcall;
    logic        instrIsMret;
    logic        irqExt;
    logic        irqTimer;
    logic [31:0] mtvecDi;
    logic [31:0] mepcDi;
    logic        mepcWe;
    logic [31:0] mepcDo;
    logic        mcauseWe;
    logic [31:0] mcauseDo;
    logic        squash;
    logic        stall;
    logic        pcWe;
    logic [31:0] pcTarget;
    logic        inTrap;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    trap_controller #(.VECTORED_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .instrValid(instrValid), .pc(pc),
        .excFetchMisaligned(excFetchMisaligned), .excIllegal(excIllegal),
        .excEbreak(excEbreak), .excEcall(excEcall), .instrIsMret(instrIsMret),
        .irqExt(irqExt), .irqTimer(irqTimer), .mtvecDi(mtvecDi), .mepcDi(mepcDi),
        .mepcWe(mepcWe), .mepcDo(mepcDo), .mcauseWe(mcauseWe), .mcauseDo(mcauseDo),
        .squash(squash), .stall(stall), .pcWe(pcWe), .pcTarget(pcTarget), .inTrap(inTrap)
    );

    // Cause chosen by scanning the priority table top to bottom.
    function automatic logic [31:0] modelCause(bit ge, bit gt, bit fm, bit il, bit eb, bit ec);
        bit          hit  [6];
        logic [31:0] code [6];
        hit  = '{ge, gt, fm, il, eb, ec};
        code = '{32'h8000000B, 32'h80000007, 32'h0, 32'h2, 32'h3, 32'hB};
        for (int k = 0; k < 6; k++) if (hit[k]) return code[k];
        return 32'h0;
    endfunction

    function automatic logic [31:0] modelTarget(logic [31:0] mtv, logic [31:0] cause);
        logic [31:0] base;
        base = mtv - (mtv % 4);
        if ((mtv % 4) == 1 && cause >= 32'h80000000) return base + (cause - 32'h80000000) * 4;
        return base;
    endfunction

    task automatic clearInputs();
        instrValid = 0; pc = 0; instrIsMret = 0;
        excFetchMisaligned = 0; excIllegal = 0; excEbreak = 0; excEcall = 0;
        irqExt = 0; irqTimer = 0;
    endtask

    task automatic junkInputs();
        instrValid = 1'($urandom); pc = $urandom; instrIsMret = 1'($urandom);
        excFetchMisaligned = 1'($urandom); excIllegal = 1'($urandom);
        excEbreak = 1'($urandom); excEcall = 1'($urandom);
        irqExt = 1'($urandom); irqTimer = 1'($urandom);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        clearInputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        instrValid = 1; excIllegal = 1; irqExt = 1; pc = 32'h10;
        #1;
        nChecks++; if (squash !== 1'b0) begin nFails++; $display("[TB] FAIL reset_squash: got %0h expected 0", squash); end
        nChecks++; if (stall !== 1'b0) begin nFails++; $display("[TB] FAIL reset_stall: got %0h expected 0", stall); end
        nChecks++; if (inTrap !== 1'b0) begin nFails++; $display("[TB] FAIL reset_inTrap: got %0h expected 0", inTrap); end
        nChecks++; if ({mepcWe, mcauseWe, pcWe} !== 3'b000) begin nFails++; $display("[TB] FAIL reset_we: got %b expected 000", {mepcWe, mcauseWe, pcWe}); end
        nChecks++; if (pcTarget !== 32'h0) begin nFails++; $display("[TB] FAIL reset_pcTarget: got %h expected 0", pcTarget); end
        clearInputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_illegal();
        @(negedge clk);
        instrValid = 1; pc = 32'h100; excIllegal = 1; mtvecDi = 32'h200;
        #1;
        nChecks++; if (squash !== 1'b1) begin nFails++; $display("[TB] FAIL illegal_squash: got %0h expected 1", squash); end
        nChecks++; if (stall !== 1'b1) begin nFails++; $display("[TB] FAIL illegal_stallN: got %0h expected 1", stall); end
        nChecks++; if (mepcWe !== 1'b0) begin nFails++; $display("[TB] FAIL illegal_mepcWeN: got %0h expected 0", mepcWe); end
        @(negedge clk);
        clearInputs();
        #1;
        nChecks++; if (mepcWe !== 1'b1 || mcauseWe !== 1'b1) begin nFails++; $display("[TB] FAIL illegal_we: got %b%b expected 11", mepcWe, mcauseWe); end
        nChecks++; if (mepcDo !== 32'h100) begin nFails++; $display("[TB] FAIL illegal_mepcDo: got %h expected 00000100", mepcDo); end
        nChecks++; if (mcauseDo !== 32'h2) begin nFails++; $display("[TB] FAIL illegal_mcauseDo: got %h expected 00000002", mcauseDo); end
        nChecks++; if (squash !== 1'b0 || stall !== 1'b1) begin nFails++; $display("[TB] FAIL illegal_stallN1: got sq=%0h st=%0h expected sq=0 st=1", squash, stall); end
        @(negedge clk);
        #1;
        nChecks++; if (pcWe !== 1'b1 || pcTarget !== 32'h200) begin nFails++; $display("[TB] FAIL illegal_redirect: got we=%0h tgt=%h expected we=1 tgt=00000200", pcWe, pcTarget); end
        nChecks++; if (inTrap !== 1'b0 || mepcWe !== 1'b0) begin nFails++; $display("[TB] FAIL illegal_N2: got inTrap=%0h mepcWe=%0h expected 0 0", inTrap, mepcWe); end
        @(negedge clk);
        #1;
        nChecks++; if (inTrap !== 1'b1) begin nFails++; $display("[TB] FAIL illegal_inTrap: got %0h expected 1", inTrap); end
        nChecks++; if (pcWe !== 1'b0 || stall !== 1'b0) begin nFails++; $display("[TB] FAIL illegal_done: got pcWe=%0h stall=%0h expected 0 0", pcWe, stall); end
    endtask

    task automatic test_nested();
        @(negedge clk);
        instrValid = 1; pc = 32'h204; excEbreak = 1; mtvecDi = 32'h200;
        #1;
        nChecks++; if (squash !== 1'b1) begin nFails++; $display("[TB] FAIL nested_squash: got %0h expected 1", squash); end
        @(negedge clk);
        clearInputs();
        #1;
        nChecks++; if (mepcDo !== 32'h204 || mcauseDo !== 32'h3) begin nFails++; $display("[TB] FAIL nested_csr: got %h/%h expected 00000204/00000003", mepcDo, mcauseDo); end
        @(negedge clk);
        #1;
        nChecks++; if (pcTarget !== 32'h200 || inTrap !== 1'b1) begin nFails++; $display("[TB] FAIL nested_redirect: got tgt=%h inTrap=%0h expected 00000200 1", pcTarget, inTrap); end
        @(negedge clk);
        #1;
        nChecks++; if (inTrap !== 1'b1) begin nFails++; $display("[TB] FAIL nested_inTrap: got %0h expected 1", inTrap); end
    endtask

    task automatic test_in_handler();
        @(negedge clk);
        instrValid = 1; pc = 32'h300; irqExt = 1;
        #1;
        nChecks++; if (squash !== 1'b0 || stall !== 1'b0) begin nFails++; $display("[TB] FAIL handler_irq_masked: got sq=%0h st=%0h expected 0 0", squash, stall); end
        @(negedge clk);
        clearInputs();
        #1;
        nChecks++; if (mepcWe !== 1'b0 || pcWe !== 1'b0) begin nFails++; $display("[TB] FAIL handler_no_seq: got mepcWe=%0h pcWe=%0h expected 0 0", mepcWe, pcWe); end
        @(negedge clk);
        instrValid = 1; instrIsMret = 1; irqExt = 1; mepcDi = 32'h84;
        #1;
        nChecks++; if (squash !== 1'b0 || stall !== 1'b0) begin nFails++; $display("[TB] FAIL mret_N: got sq=%0h st=%0h expected 0 0", squash, stall); end
        @(negedge clk);
        clearInputs();
        #1;
        nChecks++; if (pcWe !== 1'b1 || pcTarget !== 32'h84 || stall !== 1'b1) begin nFails++; $display("[TB] FAIL mret_redirect: got we=%0h tgt=%h st=%0h expected 1 00000084 1", pcWe, pcTarget, stall); end
        nChecks++; if (mepcWe !== 1'b0 || mcauseWe !== 1'b0) begin nFails++; $display("[TB] FAIL mret_no_csr: got %b%b expected 00", mepcWe, mcauseWe); end
        @(negedge clk);
        #1;
        nChecks++; if (inTrap !== 1'b0 || pcWe !== 1'b0) begin nFails++; $display("[TB] FAIL mret_inTrap: got inTrap=%0h pcWe=%0h expected 0 0", inTrap, pcWe); end
    endtask

    // Timer and ext interrupts through vectored mtvec, including a wrapping target.
    task automatic test_vectored();
        logic [31:0] mtvTab [2];
        logic [31:0] pcTab  [2];
        logic [31:0] cauTab [2];
        logic [31:0] tgtTab [2];
        mtvTab = '{32'h301, 32'hFFFFFFFD};
        pcTab  = '{32'h40, 32'h48};
        cauTab = '{32'h80000007, 32'h8000000B};
        tgtTab = '{32'h31C, 32'h28};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            instrValid = 1; pc = pcTab[k]; mtvecDi = mtvTab[k];
            irqTimer = (k == 0); irqExt = (k == 1);
            #1;
            nChecks++; if (squash !== 1'b1) begin nFails++; $display("[TB] FAIL vec%0d_squash: got %0h expected 1", k, squash); end
            @(negedge clk);
            clearInputs();
            #1;
            nChecks++; if (mcauseDo !== cauTab[k] || mepcDo !== pcTab[k]) begin nFails++; $display("[TB] FAIL vec%0d_csr: got %h/%h expected %h/%h", k, mcauseDo, mepcDo, cauTab[k], pcTab[k]); end
            @(negedge clk);
            #1;
            nChecks++; if (pcTarget !== tgtTab[k]) begin nFails++; $display("[TB] FAIL vec%0d_target: got %h expected %h", k, pcTarget, tgtTab[k]); end
            @(negedge clk);
            instrValid = 1; instrIsMret = 1; mepcDi = pcTab[k] + 4;
            @(negedge clk);
            clearInputs();
            #1;
            nChecks++; if (pcTarget !== pcTab[k] + 32'd4) begin nFails++; $display("[TB] FAIL vec%0d_mret: got %h expected %h", k, pcTarget, pcTab[k] + 32'd4); end
        end
        @(negedge clk);
        instrValid = 1; pc = 32'h50; excEcall = 1; mtvecDi = 32'h301;
        @(negedge clk);
        clearInputs();
        #1;
        nChecks++; if (mcauseDo !== 32'hB) begin nFails++; $display("[TB] FAIL vec_exc_cause: got %h expected 0000000b", mcauseDo); end
        @(negedge clk);
        #1;
        nChecks++; if (pcTarget !== 32'h300) begin nFails++; $display("[TB] FAIL vec_exc_base: got %h expected 00000300", pcTarget); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        instrValid = 1; pc = 32'h80; irqExt = 1; excEcall = 1; instrIsMret = 1;
        mtvecDi = 32'h200; mepcDi = 32'h999;
        #1;
        nChecks++; if (squash !== 1'b1) begin nFails++; $display("[TB] FAIL prio_squash: got %0h expected 1", squash); end
        @(negedge clk);
        clearInputs();
        #1;
        nChecks++; if (mcauseDo !== 32'h8000000B || mepcDo !== 32'h80) begin nFails++; $display("[TB] FAIL prio_csr: got %h/%h expected 8000000b/00000080", mcauseDo, mepcDo); end
        nChecks++; if (pcWe !== 1'b0) begin nFails++; $display("[TB] FAIL prio_no_mret: got pcWe=%0h expected 0", pcWe); end
        @(negedge clk);
        #1;
        nChecks++; if (pcTarget !== 32'h200) begin nFails++; $display("[TB] FAIL prio_target: got %h expected 00000200", pcTarget); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        instrValid = 1; pc = 32'h600; excIllegal = 1; mtvecDi = 32'h200;
        @(negedge clk);
        clearInputs();
        #1;
        nChecks++; if (mepcWe !== 1'b1) begin nFails++; $display("[TB] FAIL rmid_enter: got %0h expected 1", mepcWe); end
        #1;
        reset = 1'b0;
        #1;
        nChecks++; if (mepcWe !== 1'b0 || mcauseWe !== 1'b0 || stall !== 1'b0) begin nFails++; $display("[TB] FAIL rmid_async: got %b%b%b expected 000", mepcWe, mcauseWe, stall); end
        nChecks++; if (inTrap !== 1'b0) begin nFails++; $display("[TB] FAIL rmid_inTrap: got %0h expected 0", inTrap); end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            nChecks++; if (pcWe !== 1'b0 || mepcWe !== 1'b0) begin nFails++; $display("[TB] FAIL rmid_after%0d: got pcWe=%0h mepcWe=%0h expected 0 0", k, pcWe, mepcWe); end
        end
    endtask

    task automatic test_random();
        bit          mInTrap = 0;
        bit          v, fm, il, eb, ec, ge, gt, mr, trap, doMret;
        logic [31:0] pcv, mtv, mepv, cause;
        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            nChecks++; if (inTrap !== mInTrap) begin nFails++; $display("[TB] FAIL rnd%0d_inTrap: got %0h expected %0h", it, inTrap, mInTrap); end
            v  = $urandom_range(0, 3) != 0;
            fm = $urandom_range(0, 9) == 0; il = $urandom_range(0, 7) == 0;
            eb = $urandom_range(0, 7) == 0; ec = $urandom_range(0, 7) == 0;
            ge = $urandom_range(0, 4) == 0; gt = $urandom_range(0, 4) == 0;
            mr = $urandom_range(0, 2) == 0;
            pcv = $urandom; mtv = $urandom;
            instrValid = v; pc = pcv; excFetchMisaligned = fm; excIllegal = il;
            excEbreak = eb; excEcall = ec; irqExt = ge; irqTimer = gt;
            instrIsMret = mr; mtvecDi = mtv; mepcDi = $urandom;
            trap   = v && (fm || il || eb || ec || ((ge || gt) && !mInTrap));
            doMret = v && mr && !trap;
            cause  = modelCause(ge && !mInTrap, gt && !mInTrap, fm, il, eb, ec);
            #1;
            nChecks++; if (squash !== trap || stall !== trap) begin nFails++; $display("[TB] FAIL rnd%0d_detect: got sq=%0h st=%0h expected %0h", it, squash, stall, trap); end
            if (trap) begin
                @(negedge clk);
                junkInputs();
                #1;
                nChecks++; if (mepcWe !== 1'b1 || mcauseWe !== 1'b1 || stall !== 1'b1) begin nFails++; $display("[TB] FAIL rnd%0d_enter: got %b%b%b expected 111", it, mepcWe, mcauseWe, stall); end
                nChecks++; if (mepcDo !== pcv || mcauseDo !== cause) begin nFails++; $display("[TB] FAIL rnd%0d_csr: got %h/%h expected %h/%h", it, mepcDo, mcauseDo, pcv, cause); end
                @(negedge clk);
                junkInputs();
                mtv = $urandom; mtvecDi = mtv;
                #1;
                nChecks++; if (pcWe !== 1'b1 || pcTarget !== modelTarget(mtv, cause)) begin nFails++; $display("[TB] FAIL rnd%0d_target: got we=%0h tgt=%h expected 1 %h", it, pcWe, pcTarget, modelTarget(mtv, cause)); end
                mInTrap = 1;
            end else if (doMret) begin
                @(negedge clk);
                junkInputs();
                mepv = $urandom; mepcDi = mepv;
                #1;
                nChecks++; if (pcWe !== 1'b1 || pcTarget !== mepv || stall !== 1'b1 || mepcWe !== 1'b0) begin nFails++; $display("[TB] FAIL rnd%0d_mret: got we=%0h tgt=%h st=%0h expected 1 %h 1", it, pcWe, pcTarget, stall, mepv); end
                mInTrap = 0;
            end
        end
        @(negedge clk);
        clearInputs();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        mtvecDi = 0; mepcDi = 0;
        clearInputs();
        test_reset();
        test_illegal();
        test_nested();
        test_in_handler();
        test_vectored();
        doReset();
        test_priority();
        doReset();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
# trap_controller

Machine-mode trap sequencer that drives the trap-side ports of the CSR file. It receives exception flags, interrupt requests and `mret` from the core's commit point. It writes `mepc`/`mcause` through the CSR direct-write ports, then redirects the PC to the handler address derived from `mtvec`, or back to `mepc` on `mret`. It also tracks an in-handler flag that masks interrupts.

## Interface
- `VECTORED_EN`, default 1: when 1, `mtvec` mode 1 selects vectored interrupt targets; when 0, all traps use direct mode.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `instrValid` in 1: the instruction at `pc` is at the commit point this cycle.
- `pc` in 32: address of the committing instruction.
- `excFetchMisaligned`, `excIllegal`, `excEbreak`, `excEcall` in 1 each: synchronous exception flags for the committing instruction.
- `instrIsMret` in 1: the committing instruction is `mret`.
- `irqExt`, `irqTimer` in 1 each: level-sensitive interrupt requests.
- `mtvecDi` in 32: current `mtvec` from the CSR file.
- `mepcDi` in 32: current `mepc` from the CSR file.
- `mepcWe` out 1, `mepcDo` out 32: direct `mepc` write to the CSR file.
- `mcauseWe` out 1, `mcauseDo` out 32: direct `mcause` write to the CSR file.
- `squash` out 1: the committing instruction must not write back (register file, CSR, memory).
- `stall` out 1: the core holds fetch/commit.
- `pcWe` out 1, `pcTarget` out 32: PC redirect.
- `inTrap` out 1: handler in progress; interrupts masked.

## Operation
- States: IDLE, ENTER, REDIRECT, MRET.
- Trap condition in IDLE: `instrValid` and (any exception flag, or (any irq and !`inTrap`)).
- Cause priority, highest first; the first match sets the cause:
  - `irqExt`: 0x8000000B.
  - `irqTimer`: 0x80000007.
  - `excFetchMisaligned`: 0x00000000.
  - `excIllegal`: 0x00000002.
  - `excEbreak`: 0x00000003.
  - `excEcall`: 0x0000000B.
- IDLE with trap condition:
  - Combinationally assert `squash` and `stall`.
  - Register `pc` into savedPc and the cause into savedCause.
  - Go to ENTER.
- IDLE, `instrValid` and `instrIsMret`, no trap condition: go to MRET. No squash; `mret` commits normally.
- ENTER:
  - `mepcWe`=`mcauseWe`=1, `mepcDo`=savedPc, `mcauseDo`=savedCause, `stall`=1.
  - Go to REDIRECT.
- REDIRECT:
  - `pcWe`=1 and `pcTarget` = base, where base = {`mtvecDi`[31:2], 2'b00}.
  - If `VECTORED_EN`, `mtvecDi`[1:0]==1 and savedCause[31]==1, then `pcTarget` = base + (savedCause[30:0] << 2), truncated to 32 bits (wraps modulo 2^32).
  - Set `inTrap`=1. `stall`=1. Go to IDLE.
- MRET: `pcWe`=1, `pcTarget`=`mepcDi`, clear `inTrap`, `stall`=1, go to IDLE.
- Outside the states above, all write/redirect outputs are 0 and `mepcDo`/`mcauseDo`/`pcTarget` are 0.
- Exceptions inside a handler (`inTrap`=1) are taken normally: `mepc`/`mcause` are overwritten and `inTrap` stays 1.
- Interrupts while `inTrap`=1 are ignored. There is no pending latch, so an irq that deasserts before `mret` is lost.
- `mret` with a simultaneous exception flag: the exception wins and `mret` is squashed.
- `mret` with `inTrap`=0: still redirects to `mepcDi`.
- `instrValid`=0: no trap and no `mret` action, regardless of the flags.
- Inputs are ignored in ENTER, REDIRECT and MRET (the core is stalled).

## Timing
- Reset (`reset`=0): state is IDLE, `inTrap`=0, savedPc=savedCause=0, and every output is 0, taking effect immediately (asynchronous).
- Reset asserted mid-sequence aborts it; no partial CSR write or redirect occurs after deassertion.
- Trap sequence:
  - Detection cycle N: `squash`=`stall`=1.
  - N+1: CSR write.
  - N+2: `pcWe` and `inTrap` rises at the end of N+2.
- The CSR write in N+1 lands at the N+1 clock edge. The trap writes do not modify `mtvec`, so the REDIRECT target uses the `mtvec` value current at N+2.
- `mret`: detection cycle N, `pcWe` in N+1 with `mepcDi` sampled in N+1. `inTrap` falls at the end of N+1.
- `stall` is high for N..N+2 on a trap and for N+1 on `mret`. A new trap or `mret` can be detected at the earliest in the cycle after REDIRECT/MRET.

## Test plan
- Illegal instruction: `pc`=0x100, `excIllegal`=1, `mtvecDi`=0x200:
  - N: `squash`=1.
  - N+1: `mepcDo`=0x100, `mcauseDo`=2.
  - N+2: `pcTarget`=0x200, then `inTrap`=1.
- Vectored interrupt: `mtvecDi`=0x301, `irqTimer`=1 at `pc`=0x40 → `mcauseDo`=0x80000007, `pcTarget`=0x31C.
- Priority: `irqExt`, `excEcall` and `instrIsMret` together at `pc`=0x80 → `mcauseDo`=0x8000000B, `mret` squashed, no MRET state.
- In handler:
  - `irqExt`=1 with `instrValid` → no trap, `squash`=0.
  - Then `instrIsMret` with `mepcDi`=0x84 → N+1 `pcWe`=1, `pcTarget`=0x84, `inTrap`=0.
- Nested exception: `inTrap`=1, `excEbreak` at `pc`=0x204 → `mepcDo`=0x204, `mcauseDo`=3, `inTrap` stays 1.
- Reset: drive `reset`=0 during ENTER → `mepcWe`=0 immediately, state IDLE, `inTrap`=0, and no redirect after release.
